// File: rtl/alu_sequencer_if.sv
// Instruction, ALU and writeback bundle between the alu_sequencer and its environment.
// master = instruction source plus external ALU, slave = the sequencer.
interface alu_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs1;
  logic [1:0] in_rs2;
  logic [3:0] in_imm;

  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic [3:0] alu_op;
  logic [3:0] alu_o;
  logic       alu_cout;

  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [3:0] wb_data;
  logic       wb_carry;
  logic       carry_flag;
  logic       err;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, alu_o, alu_cout,
    input  in_ready, alu_x, alu_y, alu_op, wb_valid, wb_rd, wb_data, wb_carry,
           carry_flag, err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, alu_o, alu_cout,
    output in_ready, alu_x, alu_y, alu_op, wb_valid, wb_rd, wb_data, wb_carry,
           carry_flag, err
  );
endinterface

// File: rtl/alu_sequencer.sv
// 4x4 register-file sequencer for an external ALU: ALU op 2 cycles accept-to-wb_valid, LOAD 1 cycle; in_ready low during EXEC.
// ALU_SEQ_ILLEGAL_TRAP_EN: an illegal opcode sets sticky err and holds in_ready low until reset (otherwise it is a NOP).
module alu_sequencer (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [3:0][3:0] rf;
  logic [1:0]      rd_q;
  logic [3:0]      alu_x_q;
  logic [3:0]      alu_y_q;
  logic [3:0]      alu_op_q;
  logic            wb_valid_q;
  logic [1:0]      wb_rd_q;
  logic [3:0]      wb_data_q;
  logic            wb_carry_q;
  logic            carry_q;
  logic            err_q;

  logic            op_load;
  logic            op_alu;
  logic            op_illegal;
  logic            ready;
  logic            accept;
  logic            load_fire;
  logic            issue_fire;
  logic            exec_done;

  always_comb begin
    op_load    = (bus.in_op == 4'b0000);
    op_illegal = (bus.in_op[3:2] == 2'b11);
    op_alu     = !op_load && !op_illegal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    accept     = 1'b0;
    load_fire  = 1'b0;
    issue_fire = 1'b0;
    exec_done  = 1'b0;
    case (state)
      IDLE: begin
        ready  = !err_q;
        accept = bus.in_valid && ready;
        if (accept) begin
          load_fire  = op_load;
          issue_fire = op_alu;
          if (op_alu) begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        exec_done = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // LOAD and EXEC writeback never coincide: LOAD fires only in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf         <= '0;
      rd_q       <= 2'd0;
      alu_x_q    <= 4'd0;
      alu_y_q    <= 4'd0;
      alu_op_q   <= 4'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 2'd0;
      wb_data_q  <= 4'd0;
      wb_carry_q <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      if (load_fire) begin
        rf[bus.in_rd] <= bus.in_imm;
        wb_valid_q    <= 1'b1;
        wb_rd_q       <= bus.in_rd;
        wb_data_q     <= bus.in_imm;
        wb_carry_q    <= 1'b0;
      end
      if (issue_fire) begin
        alu_x_q  <= rf[bus.in_rs1];
        alu_y_q  <= rf[bus.in_rs2];
        alu_op_q <= bus.in_op;
        rd_q     <= bus.in_rd;
      end
      if (exec_done) begin
        rf[rd_q]   <= bus.alu_o;
        carry_q    <= bus.alu_cout;
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_q;
        wb_data_q  <= bus.alu_o;
        wb_carry_q <= bus.alu_cout;
      end
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && op_illegal) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err_q = 1'b0;
`endif

  assign bus.in_ready   = ready;
  assign bus.alu_x      = alu_x_q;
  assign bus.alu_y      = alu_y_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_carry   = wb_carry_q;
  assign bus.carry_flag = carry_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the external ALU, keeps a reference register file and
// scoreboards writeback reports against expectations queued at instruction acceptance.
module tb_alu_sequencer;

  typedef struct packed {
    logic [1:0] rd;
    logic [3:0] data;
    logic       c;
  } wb_t;

  logic clk;
  logic rst_n;
  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_cmp;
  int         n_bad;
  int         cyc;
  int         acc_cyc;
  logic [3:0] mrf [4];
  logic       mcarry;
  wb_t        exp_q[$];
  wb_t        obs_q[$];
  wb_t        o_wb;
  wb_t        e_wb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] r;
    case (op)
      4'd1:    r = {1'b0, x} + {1'b0, y};
      4'd2:    r = {1'b0, x} - {1'b0, y};
      4'd3:    r = {1'b0, x | y};
      4'd4:    r = {1'b0, x & y};
      4'd5:    r = {1'b0, x ^ y};
      4'd6:    r = {1'b0, ~x};
      4'd7:    r = {1'b0, x} + 5'd1;
      4'd8:    r = {1'b0, x} - 5'd1;
      4'd9:    r = {1'b0, x};
      4'd10:   r = {1'b0, x >> y};
      4'd11:   r = {1'b0, x << y};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    {bus.alu_cout, bus.alu_o} = alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wb_valid === 1'b1) obs_q.push_back({bus.wb_rd, bus.wb_data, bus.wb_carry});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mrf[i] = 4'd0;
    mcarry = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [3:0] imm, input bit hold, input bit push);
    logic [4:0] r;
    int         guard;
    bit         done;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 16) begin
      if (bus.in_ready === 1'b1) begin
        if (op == 4'd0) begin
          mrf[rd] = imm;
          if (push) exp_q.push_back({rd, imm, 1'b0});
        end else if (op[3:2] != 2'b11) begin
          r       = alu_f(op, mrf[rs1], mrf[rs2]);
          mrf[rd] = r[3:0];
          mcarry  = r[4];
          if (push) exp_q.push_back({rd, r[3:0], r[4]});
        end
        done = 1'b1;
      end
      step();
      guard++;
      if (done) acc_cyc = cyc;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: op=%h not accepted, required acceptance within 16 cycles", op);
    end
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_carry, bus.carry_flag, bus.err,
         bus.alu_x, bus.alu_y, bus.alu_op} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got wb_valid=%b wb_rd=%0d wb_data=%h wb_carry=%b carry=%b err=%b x=%h y=%h op=%h, required all 0",
               bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_carry, bus.carry_flag, bus.err,
               bus.alu_x, bus.alu_y, bus.alu_op);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    n_cmp++;
    if ({bus.wb_valid, bus.wb_data, bus.carry_flag, bus.err, bus.alu_x} !== 11'd0) begin
      n_bad++;
      $display("FAIL post_reset_outputs: got wb_valid=%b wb_data=%h carry=%b err=%b x=%h, required all 0",
               bus.wb_valid, bus.wb_data, bus.carry_flag, bus.err, bus.alu_x);
    end
    model_reset();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_load_add();
    issue(4'd0, 2'd1, 2'd0, 2'd0, 4'd9, 1'b0, 1'b1);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL load_keeps_ready: got in_ready=%b, required 1", bus.in_ready);
    end
    issue(4'd0, 2'd2, 2'd0, 2'd0, 4'd8, 1'b0, 1'b1);
    issue(4'd1, 2'd3, 2'd1, 2'd2, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if ({bus.alu_x, bus.alu_y, bus.alu_op, bus.in_ready} !== {4'd9, 4'd8, 4'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL add_issue: got x=%h y=%h op=%h in_ready=%b, required x=9 y=8 op=1 in_ready=0",
               bus.alu_x, bus.alu_y, bus.alu_op, bus.in_ready);
    end
    step();
    n_cmp++;
    if ({bus.in_ready, bus.wb_valid, bus.carry_flag} !== {1'b1, 1'b1, mcarry}) begin
      n_bad++;
      $display("FAIL add_done: got in_ready=%b wb_valid=%b carry=%b, required 1 1 %b",
               bus.in_ready, bus.wb_valid, bus.carry_flag, mcarry);
    end
    n_cmp++;
    if ({bus.wb_rd, bus.wb_data, bus.wb_carry} !== {2'd3, 4'h1, 1'b1}) begin
      n_bad++;
      $display("FAIL add_result: got rd=%0d data=%h c=%b, required rd=3 data=1 c=1",
               bus.wb_rd, bus.wb_data, bus.wb_carry);
    end
    issue(4'd0, 2'd3, 2'd0, 2'd0, 4'd5, 1'b0, 1'b1);
    step();
    n_cmp++;
    if ({bus.carry_flag, bus.alu_x, bus.alu_y, bus.alu_op} !== {1'b1, 4'd9, 4'd8, 4'd1}) begin
      n_bad++;
      $display("FAIL load_holds_alu: got carry=%b x=%h y=%h op=%h, required carry=1 x=9 y=8 op=1",
               bus.carry_flag, bus.alu_x, bus.alu_y, bus.alu_op);
    end
    step();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL load_add_count: got %0d wb pulses, required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_wb = obs_q.pop_front();
      e_wb = exp_q.pop_front();
      n_cmp++;
      if (o_wb !== e_wb) begin
        n_bad++;
        $display("FAIL load_add_wb: got rd=%0d data=%h c=%b, required rd=%0d data=%h c=%b",
                 o_wb.rd, o_wb.data, o_wb.c, e_wb.rd, e_wb.data, e_wb.c);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_logic();
    issue(4'd4, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0, 1'b1);
    issue(4'd11, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1);
    step();
    step();
    n_cmp++;
    if (bus.carry_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL logic_carry: got %b, required 0", bus.carry_flag);
    end
    n_cmp++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      n_bad++;
      $display("FAIL logic_count: got %0d wb pulses, required 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_wb = obs_q.pop_front();
      e_wb = exp_q.pop_front();
      n_cmp++;
      if (o_wb !== e_wb) begin
        n_bad++;
        $display("FAIL logic_wb: got rd=%0d data=%h c=%b, required rd=%0d data=%h c=%b",
                 o_wb.rd, o_wb.data, o_wb.c, e_wb.rd, e_wb.data, e_wb.c);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int a0;
    int a1;
    issue(4'd1, 2'd1, 2'd1, 2'd2, 4'd0, 1'b1, 1'b1);
    a0 = acc_cyc;
    issue(4'd1, 2'd2, 2'd1, 2'd1, 4'd0, 1'b1, 1'b1);
    a1 = acc_cyc;
    n_cmp++;
    if (a1 - a0 != 2) begin
      n_bad++;
      $display("FAIL alu_spacing_1: got %0d cycles between accepts, required 2", a1 - a0);
    end
    issue(4'd1, 2'd3, 2'd2, 2'd1, 4'd0, 1'b1, 1'b1);
    n_cmp++;
    if (acc_cyc - a1 != 2) begin
      n_bad++;
      $display("FAIL alu_spacing_2: got %0d cycles between accepts, required 2", acc_cyc - a1);
    end
    issue(4'd0, 2'd0, 2'd0, 2'd0, 4'd3, 1'b1, 1'b1);
    a0 = acc_cyc;
    issue(4'd0, 2'd1, 2'd0, 2'd0, 4'd4, 1'b1, 1'b1);
    a1 = acc_cyc;
    issue(4'd0, 2'd2, 2'd0, 2'd0, 4'd5, 1'b0, 1'b1);
    n_cmp++;
    if (a1 - a0 != 1 || acc_cyc - a1 != 1) begin
      n_bad++;
      $display("FAIL load_spacing: got %0d and %0d cycles between accepts, required 1 and 1",
               a1 - a0, acc_cyc - a1);
    end
    step();
    step();
    n_cmp++;
    if (obs_q.size() != 6 || exp_q.size() != 6) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d wb pulses, required 6", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_wb = obs_q.pop_front();
      e_wb = exp_q.pop_front();
      n_cmp++;
      if (o_wb !== e_wb) begin
        n_bad++;
        $display("FAIL b2b_wb: got rd=%0d data=%h c=%b, required rd=%0d data=%h c=%b",
                 o_wb.rd, o_wb.data, o_wb.c, e_wb.rd, e_wb.data, e_wb.c);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_illegal();
    issue(4'b1110, 2'd1, 2'd0, 2'd0, 4'd15, 1'b0, 1'b1);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    n_cmp++;
    if ({bus.err, bus.in_ready, bus.wb_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL trap_set: got err=%b in_ready=%b wb_valid=%b, required 1 0 0",
               bus.err, bus.in_ready, bus.wb_valid);
    end
    bus.in_op    = 4'd0;
    bus.in_rd    = 2'd0;
    bus.in_imm   = 4'd12;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.err, bus.in_ready} !== 2'b10 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL trap_hold: got err=%b in_ready=%b wb pulses=%0d, required 1 0 0",
               bus.err, bus.in_ready, obs_q.size());
    end
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    model_reset();
    n_cmp++;
    if ({bus.err, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL trap_clear: got err=%b in_ready=%b, required 0 1", bus.err, bus.in_ready);
    end
`else
    begin
      int a0;
      a0 = acc_cyc;
      n_cmp++;
      if ({bus.err, bus.in_ready, bus.wb_valid} !== 3'b010) begin
        n_bad++;
        $display("FAIL nop_state: got err=%b in_ready=%b wb_valid=%b, required 0 1 0",
                 bus.err, bus.in_ready, bus.wb_valid);
      end
      issue(4'd0, 2'd3, 2'd0, 2'd0, 4'd7, 1'b0, 1'b1);
      n_cmp++;
      if (acc_cyc - a0 != 1) begin
        n_bad++;
        $display("FAIL nop_next_load: got %0d cycles to next accept, required 1", acc_cyc - a0);
      end
      step();
      n_cmp++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
        n_bad++;
        $display("FAIL nop_count: got %0d wb pulses, required 1", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o_wb = obs_q.pop_front();
        e_wb = exp_q.pop_front();
        n_cmp++;
        if (o_wb !== e_wb) begin
          n_bad++;
          $display("FAIL nop_wb: got rd=%0d data=%h c=%b, required rd=%0d data=%h c=%b",
                   o_wb.rd, o_wb.data, o_wb.c, e_wb.rd, e_wb.data, e_wb.c);
        end
      end
    end
`endif
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_exec();
    issue(4'd0, 2'd1, 2'd0, 2'd0, 4'd6, 1'b0, 1'b0);
    step();
    obs_q.delete();
    issue(4'd1, 2'd2, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (bus.wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_wb_valid: got %b, required 0", bus.wb_valid);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    model_reset();
    n_cmp++;
    if (obs_q.size() != 0 || bus.carry_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_wb: got %0d wb pulses carry=%b, required 0 pulses carry=0",
               obs_q.size(), bus.carry_flag);
    end
    obs_q.delete();
    issue(4'd1, 2'd3, 2'd2, 2'd2, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if ({bus.alu_x, bus.alu_y} !== 8'd0) begin
      n_bad++;
      $display("FAIL abort_rf2: got r2 operands x=%h y=%h, required 0 0", bus.alu_x, bus.alu_y);
    end
    step();
    step();
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_bad++;
      $display("FAIL abort_count: got %0d wb pulses, required 1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_wb = obs_q.pop_front();
      e_wb = exp_q.pop_front();
      n_cmp++;
      if (o_wb !== e_wb) begin
        n_bad++;
        $display("FAIL abort_wb: got rd=%0d data=%h c=%b, required rd=%0d data=%h c=%b",
                 o_wb.rd, o_wb.data, o_wb.c, e_wb.rd, e_wb.data, e_wb.c);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    cyc          = 0;
    acc_cyc      = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = 4'd0;
    bus.in_rd    = 2'd0;
    bus.in_rs1   = 2'd0;
    bus.in_rs2   = 2'd0;
    bus.in_imm   = 4'd0;
    model_reset();
    test_reset();
    test_load_add();
    test_logic();
    test_back_to_back();
    test_illegal();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, instruction offered.
REQ-004 SHALL have port in_ready, output, 1, instruction accepted when in_valid and in_ready are both high at a clk edge.
REQ-005 SHALL have port in_op, input, 4, opcode: 4'b0000 LOAD, 4'b0001-4'b1011 ALU ops, 4'b1100-4'b1111 illegal.
REQ-006 SHALL have ports in_rd, in_rs1, in_rs2, input, 2 each, destination and source register indices.
REQ-007 SHALL have port in_imm, input, 4, LOAD immediate.
REQ-008 SHALL have ports alu_x, alu_y, alu_op, output, 4 each, registered operands and opcode driven to the downstream ALU.
REQ-009 SHALL have ports alu_o, input, 4, and alu_cout, input, 1, combinational ALU result and carry.
REQ-010 SHALL have ports wb_valid, output, 1; wb_rd, output, 2; wb_data, output, 4; wb_carry, output, 1; writeback report.
REQ-011 SHALL have port carry_flag, output, 1, carry of last completed ALU op.
REQ-012 SHALL have port err, output, 1, sticky illegal-op trap (see Configuration).

Function
REQ-013 SHALL hold a 4-entry x 4-bit register file r0-r3, all general purpose.
REQ-014 SHALL implement states IDLE, EXEC; in_ready high only in IDLE with err low.
REQ-015 SHALL on accepted ALU op (0001-1011): load alu_x=rf[rs1], alu_y=rf[rs2], alu_op=in_op, latch rd, go to EXEC.
REQ-016 SHALL in EXEC (exactly one cycle) capture alu_o into rf[rd], alu_cout into carry_flag at the closing edge, and return to IDLE.
REQ-017 SHALL pulse wb_valid for one cycle after the EXEC closing edge, with wb_rd=rd, wb_data=alu_o, wb_carry=alu_cout as captured.
REQ-018 SHALL on accepted LOAD write in_imm to rf[rd] at the accept edge, stay in IDLE, pulse wb_valid next cycle with wb_data=in_imm, wb_carry=0; carry_flag unchanged; alu_* unchanged.
REQ-019 SHALL sample sources at accept; a write from the previous instruction is always visible (writeback completes before next accept).
REQ-020 SHALL give throughput one ALU op per 2 cycles, one LOAD per cycle.
REQ-021 SHALL hold alu_x, alu_y, alu_op at last values outside EXEC; wb_data/wb_rd/wb_carry hold last values when wb_valid low.

Reset
REQ-022 SHALL on rst_n low at an edge: state IDLE, rf all 0, alu_x=alu_y=alu_op=0, wb_valid=0, wb_rd=0, wb_data=0, wb_carry=0, carry_flag=0, err=0; in_ready high the cycle after rst_n deasserts.
REQ-023 SHALL on reset during EXEC abort the op: no rf write, no wb_valid pulse; reset takes priority over every other event.

Configuration
REQ-024 SHALL with ALU_SEQ_ILLEGAL_TRAP_EN defined: accepted illegal op sets err at the accept edge, no rf write, no wb_valid; in_ready stays low until reset.
REQ-025 SHALL without ALU_SEQ_ILLEGAL_TRAP_EN: illegal op accepted as NOP (no rf write, no wb_valid, state IDLE), err tied 0.

Verification
REQ-026 Reset held 2 cycles, release -> all outputs 0, in_ready=1 next cycle.
REQ-027 LOAD r1=9, LOAD r2=8, ADD(0001) r3=r1+r2 -> wb_valid pulses x3; ADD wb_rd=3, wb_data=4'h1, wb_carry=1, carry_flag=1, in_ready low exactly one cycle.
REQ-028 After REQ-027, AND(0100) r0=r1&r2 then SHL(1011) r0=r0 -> wb_data=4'h8 then 4'h0, wb_carry=0 both.
REQ-029 in_valid held high for three ADDs -> accepts every 2nd cycle, three wb_valid pulses, no drop or duplicate.
REQ-030 in_op=4'b1110 -> with macro: err=1, in_ready=0 until reset; without: no wb_valid, err=0, next LOAD accepted next cycle.
REQ-031 rst_n low in EXEC of ADD r2 -> no wb_valid, rf[2]=0 after reset.
